ps2_tx_frame_shifter: RTL and testbench

//  Parametrised successor of the PS/2 transmit shift register. It builds a complete

---
 rtl/ps2_tx_frame_shifter_pkg.sv | 32 +++
 rtl/ps2_tx_frame_shifter_if.sv | 32 +++
 rtl/ps2_tx_frame_shifter_clk_edge_sync.sv | 36 +++
 rtl/ps2_tx_frame_shifter.sv | 160 ++++++++++++++++
 tb/tb_ps2_tx_frame_shifter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_tx_frame_shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_tx_frame_shifter_pkg
// Description : Shared state encodings, parity modes and parity helper for
//               the PS/2 host-to-device frame shifter.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_tx_frame_shifter_pkg;

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_shift = 2'd1;
   localparam logic [1:0] c_st_ack   = 2'd2;
   localparam logic [1:0] c_st_done  = 2'd3;

   localparam int c_parity_none = 0;
   localparam int c_parity_odd  = 1;
   localparam int c_parity_even = 2;

   // Callers zero-extend the payload; the extra zeros do not affect the XOR.
   function automatic logic ps2_parity(input logic [15:0] data, input int mode);
      logic x;
      x = ^data;
      if (mode == c_parity_odd) begin
         return ~x;
      end else if (mode == c_parity_even) begin
         return x;
      end
      return 1'b0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_tx_frame_shifter_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_tx_frame_shifter_if
// Description : Command-side handshake and PS/2 pad signals of the shifter.
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_tx_frame_shifter_if #(
   parameter int DATA_BITS = 8
);
   logic                 write;
   logic [DATA_BITS-1:0] data;
   logic                 shift_en;
   logic                 ps2_clk_in;
   logic                 ps2_data_in;
   logic                 ready;
   logic                 busy;
   logic                 q;
   logic                 done;
   logic                 ack_ok;
   logic                 error;

   modport master (
      output write, data, shift_en, ps2_clk_in, ps2_data_in,
      input  ready, busy, q, done, ack_ok, error
   );

   modport slave (
      input  write, data, shift_en, ps2_clk_in, ps2_data_in,
      output ready, busy, q, done, ack_ok, error
   );
endinterface
`default_nettype wire

// File: rtl/ps2_tx_frame_shifter_clk_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : ps2_tx_frame_shifter_clk_edge_sync
// Description : Multi-stage synchroniser for a raw PS/2 line with a one-cycle
//               falling-edge strobe on the synchronised level.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_tx_frame_shifter_clk_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic nreset,
   input  logic i_pad,
   output logic o_level,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   // Preset to the idle-high line level so reset never fakes an edge.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_sync <= '1;
         r_prev <= 1'b1;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_fall  = r_prev & ~r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/ps2_tx_frame_shifter.sv
`default_nettype none
// ============================================================================
// Module      : ps2_tx_frame_shifter
// Description : Builds a PS/2 host-to-device frame, shifts it out on device
//               clock falling edges and samples the device ACK bit.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_tx_frame_shifter
   import ps2_tx_frame_shifter_pkg::*;
#(
   parameter int DATA_BITS      = 8,
   parameter int PARITY_MODE    = 1,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 15000
) (
   input  logic                 clk,
   input  logic                 nreset,
   ps2_tx_frame_shifter_if.slave bus
);

   localparam int c_frame_len = DATA_BITS + 2 + ((PARITY_MODE != 0) ? 1 : 0);
   localparam int c_bit_w     = $clog2(c_frame_len);
   localparam int c_time_w    = $clog2(TIMEOUT_CYCLES);
   localparam logic [c_bit_w-1:0]  c_last_bit  = c_bit_w'(c_frame_len - 1);
   localparam logic [c_time_w-1:0] c_time_last = c_time_w'(TIMEOUT_CYCLES - 1);

   logic [1:0]             r_state;
   logic [1:0]             w_state_next;
   logic [c_frame_len-1:0] r_shift;
   logic [c_frame_len-1:0] w_frame;
   logic [c_bit_w-1:0]     r_bit_cnt;
   logic [c_time_w-1:0]    r_time_cnt;
   logic                   r_ack_ok;
   logic                   r_error;

   logic w_clk_fall;
   logic w_clk_level_unused;
   logic w_data_level;
   logic w_data_fall_unused;
   logic w_active;
   logic w_timeout;
   logic w_edge_acc;
   logic w_last_bit;

   ps2_tx_frame_shifter_clk_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_clk_sync (
      .clk     (clk),
      .nreset  (nreset),
      .i_pad   (bus.ps2_clk_in),
      .o_level (w_clk_level_unused),
      .o_fall  (w_clk_fall)
   );

   ps2_tx_frame_shifter_clk_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_data_sync (
      .clk     (clk),
      .nreset  (nreset),
      .i_pad   (bus.ps2_data_in),
      .o_level (w_data_level),
      .o_fall  (w_data_fall_unused)
   );

   // Frame bit 0 is the start bit, so Q is simply the LSB of the shifter.
   generate
      if (PARITY_MODE != c_parity_none) begin : g_with_parity
         assign w_frame = {1'b1, ps2_parity(16'(bus.data), PARITY_MODE), bus.data, 1'b0};
      end else begin : g_no_parity
         assign w_frame = {1'b1, bus.data, 1'b0};
      end
   endgenerate

   assign w_active   = (r_state == c_st_shift) || (r_state == c_st_ack);
   assign w_timeout  = w_active && bus.shift_en && (r_time_cnt == c_time_last);
   assign w_edge_acc = w_active && bus.shift_en && w_clk_fall && !w_timeout;
   assign w_last_bit = (r_bit_cnt == c_last_bit);

   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_state <= c_st_idle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_st_idle: begin
            if (bus.write) begin
               w_state_next = c_st_shift;
            end
         end
         c_st_shift: begin
            if (w_timeout) begin
               w_state_next = c_st_idle;
            end else if (w_edge_acc && w_last_bit) begin
               w_state_next = c_st_ack;
            end
         end
         c_st_ack: begin
            if (w_timeout) begin
               w_state_next = c_st_idle;
            end else if (w_edge_acc) begin
               w_state_next = c_st_done;
            end
         end
         c_st_done: begin
            w_state_next = c_st_idle;
         end
         default: begin
            w_state_next = c_st_idle;
         end
      endcase
   end

   always_comb begin
      bus.ready  = (r_state == c_st_idle);
      bus.busy   = (r_state != c_st_idle);
      bus.q      = (r_state == c_st_shift) ? r_shift[0] : 1'b1;
      bus.done   = (r_state == c_st_done);
      bus.ack_ok = r_ack_ok;
      bus.error  = r_error;
   end

   // Edges arriving while shifting is disabled are dropped, not queued.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_shift    <= '1;
         r_bit_cnt  <= '0;
         r_time_cnt <= '0;
         r_ack_ok   <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_error <= 1'b0;
         if ((r_state == c_st_idle) && bus.write) begin
            r_shift    <= w_frame;
            r_bit_cnt  <= '0;
            r_time_cnt <= '0;
            r_ack_ok   <= 1'b0;
         end else if (w_timeout) begin
            r_error <= 1'b1;
         end else if (w_edge_acc) begin
            r_time_cnt <= '0;
            if ((r_state == c_st_shift) && !w_last_bit) begin
               r_shift   <= {1'b1, r_shift[c_frame_len-1:1]};
               r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (r_state == c_st_ack) begin
               r_ack_ok <= ~w_data_level;
            end
         end else if (w_active && bus.shift_en) begin
            r_time_cnt <= r_time_cnt + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ps2_tx_frame_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_tx_frame_shifter
// Description : Three shifter variants run in lockstep against a frame-level
//               model, plus hand-computed frame and latency expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_tx_frame_shifter;

   localparam int HALF = 8;
   localparam int PH_IDLE = 0;
   localparam int PH_SEND = 1;
   localparam int PH_WAIT_ACK = 2;
   localparam int PH_FINISHED = 3;

   logic       clk = 1'b0;
   logic       nreset;
   logic       write;
   logic       shift_en;
   logic       pclk;
   logic       pdat;
   logic [7:0] data_a;
   logic [7:0] data_b;
   logic [8:0] data_c;

   ps2_tx_frame_shifter_if #(.DATA_BITS(8)) if_a ();
   ps2_tx_frame_shifter_if #(.DATA_BITS(8)) if_b ();
   ps2_tx_frame_shifter_if #(.DATA_BITS(9)) if_c ();

   assign if_a.write = write;  assign if_b.write = write;  assign if_c.write = write;
   assign if_a.shift_en = shift_en; assign if_b.shift_en = shift_en; assign if_c.shift_en = shift_en;
   assign if_a.ps2_clk_in = pclk; assign if_b.ps2_clk_in = pclk; assign if_c.ps2_clk_in = pclk;
   assign if_a.ps2_data_in = pdat; assign if_b.ps2_data_in = pdat; assign if_c.ps2_data_in = pdat;
   assign if_a.data = data_a;  assign if_b.data = data_b;  assign if_c.data = data_c;

   ps2_tx_frame_shifter u_a (.clk(clk), .nreset(nreset), .bus(if_a));
   ps2_tx_frame_shifter #(.PARITY_MODE(2), .TIMEOUT_CYCLES(1000)) u_b (
      .clk(clk), .nreset(nreset), .bus(if_b));
   ps2_tx_frame_shifter #(.DATA_BITS(9), .PARITY_MODE(0)) u_c (
      .clk(clk), .nreset(nreset), .bus(if_c));

   always #5 clk = ~clk;

   logic a_q[3], a_rdy[3], a_bsy[3], a_done[3], a_ack[3], a_err[3];
   assign a_q[0] = if_a.q;      assign a_q[1] = if_b.q;      assign a_q[2] = if_c.q;
   assign a_rdy[0] = if_a.ready; assign a_rdy[1] = if_b.ready; assign a_rdy[2] = if_c.ready;
   assign a_bsy[0] = if_a.busy;  assign a_bsy[1] = if_b.busy;  assign a_bsy[2] = if_c.busy;
   assign a_done[0] = if_a.done; assign a_done[1] = if_b.done; assign a_done[2] = if_c.done;
   assign a_ack[0] = if_a.ack_ok; assign a_ack[1] = if_b.ack_ok; assign a_ack[2] = if_c.ack_ok;
   assign a_err[0] = if_a.error; assign a_err[1] = if_b.error; assign a_err[2] = if_c.error;

   int n_checks = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;
   int done_cnt[3] = '{0, 0, 0};
   int err_cnt[3] = '{0, 0, 0};
   int c_nb[3] = '{8, 8, 9};
   int c_pm[3] = '{1, 2, 0};
   int c_tmo[3] = '{15000, 1000, 15000};

   task automatic check(input string nm, input int inst, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d]: got %0h, expected %0h at %0t", nm, inst, act, exp, $time);
   endtask

   // Frame as the line must carry it: start, payload LSB first, parity, stop.
   function automatic logic [16:0] make_frame(input int nb, input int pm, input logic [15:0] d);
      logic [16:0] f;
      int ones;
      f = '1;
      ones = $countones(d);
      f[0] = 1'b0;
      for (int k = 0; k < nb; k++) f[k+1] = d[k];
      if (pm == 1) f[nb+1] = (ones % 2 == 0);
      else if (pm == 2) f[nb+1] = (ones % 2 == 1);
      return f;
   endfunction

   function automatic logic [15:0] din(input int i);
      if (i == 0) return {8'h00, data_a};
      if (i == 1) return {8'h00, data_b};
      return {7'h00, data_c};
   endfunction

   int          m_ph[3], m_pos[3], m_len[3], m_tc[3];
   logic        m_ack[3], m_err[3];
   logic [16:0] m_frame[3];
   logic [3:0]  h_clk, h_dat;
   logic        m_fall, m_dsamp;

   // Pad samples reach the control logic two clocks late; a fall is seen one clock later.
   always @(posedge clk) begin
      m_fall  = h_clk[2] & ~h_clk[1];
      m_dsamp = h_dat[1];
      for (int i = 0; i < 3; i++) begin
         if (!nreset) begin
            m_ph[i] = PH_IDLE; m_ack[i] = 1'b0; m_err[i] = 1'b0; m_tc[i] = 0;
         end else begin
            m_err[i] = 1'b0;
            if (m_ph[i] == PH_IDLE) begin
               if (write) begin
                  m_frame[i] = make_frame(c_nb[i], c_pm[i], din(i));
                  m_len[i] = c_nb[i] + 2 + ((c_pm[i] != 0) ? 1 : 0);
                  m_pos[i] = 0; m_tc[i] = 0; m_ack[i] = 1'b0; m_ph[i] = PH_SEND;
               end
            end else if (m_ph[i] == PH_FINISHED) begin
               m_ph[i] = PH_IDLE;
            end else if (shift_en) begin
               if (m_tc[i] == c_tmo[i] - 1) begin
                  m_err[i] = 1'b1; m_ph[i] = PH_IDLE;
               end else if (m_fall) begin
                  m_tc[i] = 0;
                  if (m_ph[i] == PH_WAIT_ACK) begin
                     m_ack[i] = ~m_dsamp; m_ph[i] = PH_FINISHED;
                  end else if (m_pos[i] == m_len[i] - 1) m_ph[i] = PH_WAIT_ACK;
                  else m_pos[i]++;
               end else m_tc[i]++;
            end
         end
      end
      if (!nreset) begin
         h_clk = 4'hF; h_dat = 4'hF;
      end else begin
         h_clk = {h_clk[2:0], pclk}; h_dat = {h_dat[2:0], pdat};
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            check("q", i, a_q[i], (m_ph[i] == PH_SEND) ? m_frame[i][m_pos[i]] : 1'b1);
            check("ready", i, a_rdy[i], m_ph[i] == PH_IDLE);
            check("busy", i, a_bsy[i], m_ph[i] != PH_IDLE);
            check("done", i, a_done[i], m_ph[i] == PH_FINISHED);
            check("ack_ok", i, a_ack[i], m_ack[i]);
            check("error", i, a_err[i], m_err[i]);
            if (a_done[i]) done_cnt[i]++;
            if (a_err[i]) err_cnt[i]++;
         end
      end
   end

   logic [10:0] sq[3];
   int cap_idx;

   task automatic pulse(input bit ack_low);
      @(negedge clk);
      if (cap_idx < 11) begin
         sq[0][cap_idx] = if_a.q; sq[1][cap_idx] = if_b.q; sq[2][cap_idx] = if_c.q;
         cap_idx++;
      end
      pclk = 1'b0;
      pdat = ack_low ? 1'b0 : 1'b1;
      repeat (HALF) @(negedge clk);
      pclk = 1'b1;
      pdat = 1'b1;
      repeat (HALF - 1) @(negedge clk);
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] b, input logic [8:0] c);
      @(negedge clk);
      write = 1'b1; data_a = a; data_b = b; data_c = c;
      @(negedge clk);
      write = 1'b0;
   endtask

   int   cnt;
   logic q_hold;

   initial begin
      nreset = 1'b0; write = 1'b0; shift_en = 1'b1; pclk = 1'b1; pdat = 1'b1;
      data_a = '0; data_b = '0; data_c = '0; cap_idx = 0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check("rst_q", 0, if_a.q, 1'b1);
      check("rst_ready", 0, if_a.ready, 1'b1);
      check("rst_done", 0, if_a.done, 1'b0);
      check("rst_ack_ok", 0, if_a.ack_ok, 1'b0);
      check("rst_error", 0, if_a.error, 1'b0);
      nreset = 1'b1;

      // Odd / even / no-parity frames, device ACKs.
      cap_idx = 0;
      do_write(8'hAE, 8'hAE, 9'h1FF);
      repeat (11) pulse(1'b0);
      pulse(1'b1);
      repeat (6) @(negedge clk);
      check("seq_odd", 0, sq[0], 11'b10101011100);
      check("seq_even", 1, sq[1], 11'b11101011100);
      check("seq_nopar", 2, sq[2], 11'b11111111110);
      check("done_cnt", 0, done_cnt[0], 1);
      check("done_cnt", 2, done_cnt[2], 1);
      check("ack_low", 0, if_a.ack_ok, 1'b1);

      // No ACK from the device.
      do_write(8'h5A, 8'h5A, 9'h0F0);
      repeat (12) pulse(1'b0);
      repeat (6) @(negedge clk);
      check("ack_high", 0, if_a.ack_ok, 1'b0);
      check("noack_err", 0, err_cnt[0], 0);
      check("done_cnt", 0, done_cnt[0], 2);

      // Shifting paused across two edges mid-frame.
      do_write(8'h35, 8'hC3, 9'h0AA);
      repeat (4) pulse(1'b0);
      @(negedge clk);
      shift_en = 1'b0;
      check("pause_q", 0, if_a.q, 1'b0);
      repeat (2) pulse(1'b0);
      repeat (10) @(negedge clk);
      check("pause_hold_q", 0, if_a.q, 1'b0);
      check("pause_busy", 0, if_a.ready, 1'b0);
      shift_en = 1'b1;
      repeat (7) pulse(1'b0);
      pulse(1'b1);
      repeat (6) @(negedge clk);
      check("resume_done", 0, done_cnt[0], 3);
      check("resume_ack", 0, if_a.ack_ok, 1'b1);

      // Clock stops after three edges; the short-timeout variant must abort.
      do_write(8'h12, 8'h12, 9'h012);
      repeat (2) pulse(1'b0);
      @(negedge clk);
      pclk = 1'b0;
      cnt = 0;
      while (!if_b.error && cnt < 1200) begin
         @(negedge clk);
         cnt++;
      end
      check("tmo_latency", 1, cnt, 1003);
      check("tmo_ready", 1, if_b.ready, 1'b1);
      check("tmo_q", 1, if_b.q, 1'b1);
      pclk = 1'b1;
      repeat (4) @(negedge clk);
      check("tmo_no_done", 1, done_cnt[1], 3);
      check("tmo_err_cnt", 1, err_cnt[1], 1);

      // Reset mid-frame with a Write issued while busy.
      @(negedge clk); nreset = 1'b0;
      @(negedge clk); nreset = 1'b1;
      do_write(8'h77, 8'h77, 9'h077);
      repeat (3) pulse(1'b0);
      do_write(8'h11, 8'h22, 9'h033);
      @(negedge clk); nreset = 1'b0;
      @(negedge clk); nreset = 1'b1;
      check("rst2_q", 0, if_a.q, 1'b1);
      check("rst2_ready", 0, if_a.ready, 1'b1);
      repeat (14) pulse(1'b0);
      repeat (6) @(negedge clk);
      check("rst2_no_frame", 0, done_cnt[0], 3);
      check("rst2_no_frame", 2, done_cnt[2], 3);
      check("rst2_idle", 0, if_a.ready, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
